// File: rtl/logic_pkg.sv
// Shared definitions for the logic unit pipeline: operation codes.
package logic_pkg;

  typedef enum logic [2:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_XOR     = 3'd2,
    OP_XNOR    = 3'd3,
    OP_NAND    = 3'd4,
    OP_NOR     = 3'd5,
    OP_ACC_XOR = 3'd6,
    OP_ACC_CLR = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_eval.sv
// Combinational operation evaluator: bitwise ops on a/b, plus checksum update ops.
module logic_op_eval
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] acc_out
);

  always_comb begin
    y       = '0;
    acc_out = acc_in;
    unique case (op)
      OP_AND:     y = a & b;
      OP_OR:      y = a | b;
      OP_XOR:     y = a ^ b;
      OP_XNOR:    y = ~(a ^ b);
      OP_NAND:    y = ~(a & b);
      OP_NOR:     y = ~(a | b);
      OP_ACC_XOR: begin
        acc_out = acc_in ^ a ^ b;
        y       = acc_in ^ a ^ b;
      end
      OP_ACC_CLR: begin
        acc_out = '0;
        y       = '0;
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage logic unit: S1 captures operands, S2 evaluates and registers result and checksum.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_par,
  output logic [WIDTH-1:0] acc,
  output logic [CNTW-1:0]  count
);

  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNTW-1:0]  count_q, count_d;

  logic             en;
  logic [WIDTH-1:0] eval_y;
  logic [WIDTH-1:0] eval_acc;

  // Whole pipe advances together; a held output freezes both stages.
  assign en = !out_valid_q || out_ready;

  logic_op_eval #(.WIDTH(WIDTH)) u_eval (
    .op      (s1_op_q),
    .a       (s1_a_q),
    .b       (s1_b_q),
    .acc_in  (acc_q),
    .y       (eval_y),
    .acc_out (eval_acc)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    acc_d       = acc_q;
    count_d     = count_q;

    if (en) begin
      s1_valid_d  = in_valid;
      s1_op_d     = op_e'(op);
      s1_a_d      = a;
      s1_b_d      = b;
      out_valid_d = s1_valid_q;
      // Bubbles leave y and the checksum untouched.
      if (s1_valid_q) begin
        y_d   = eval_y;
        acc_d = eval_acc;
      end
    end

    if (out_valid_q && out_ready && (count_q != {CNTW{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_AND;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign y_par     = ^y_q;
  assign acc       = acc_q;
  assign count     = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: scoreboard model plus directed literal scenarios.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic        in_ready, out_valid, y_par;
  logic [7:0]  y, acc;
  logic [15:0] count;
  logic        in_ready4, out_valid4, y_par4;
  logic [7:0]  y4, acc4;
  logic [3:0]  count4;

  logic_unit_pipe #(.WIDTH(8), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_par(y_par), .acc(acc), .count(count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .op(op), .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
    .y(y4), .y_par(y_par4), .acc(acc4), .count(count4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each accepted op carries its expected result and the checksum after it.
  typedef struct {
    logic [7:0] y;
    logic [7:0] acc;
    int         age;
  } item_t;

  item_t      q[$];
  logic [7:0] m_acc = 8'h00;
  int         m_count = 0;
  logic [7:0] log_y[$];
  logic       log_par[$];
  bit         ov, en;
  item_t      it;

  function automatic logic [7:0] ref_bitwise(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0:    return x & z;
      3'd1:    return x | z;
      3'd2:    return x ^ z;
      3'd3:    return ~(x ^ z);
      3'd4:    return ~(x & z);
      default: return ~(x | z);
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_acc   = 8'h00;
      m_count = 0;
    end else begin
      ov = (q.size() > 0) && (q[0].age >= 2);
      chk("out_valid", out_valid, ov);
      chk("out_valid4", out_valid4, ov);
      chk("in_ready", in_ready, !ov || out_ready);
      if (ov) begin
        chk("y", y, q[0].y);
        chk("acc", acc, q[0].acc);
        chk("y_par", y_par, ^q[0].y);
        chk("y4", y4, q[0].y);
      end
      chk("count", count, m_count);
      chk("count4", count4, (m_count > 15) ? 15 : m_count);

      en = !ov || out_ready;
      if (ov && out_ready) begin
        log_y.push_back(q[0].y);
        log_par.push_back(^q[0].y);
        void'(q.pop_front());
        if (m_count < 65535) m_count++;
      end
      if (en) begin
        foreach (q[i]) q[i].age++;
        if (in_valid) begin
          if (op == 3'd6) begin
            m_acc = m_acc ^ a ^ b;
            it.y  = m_acc;
          end else if (op == 3'd7) begin
            m_acc = 8'h00;
            it.y  = 8'h00;
          end else begin
            it.y = ref_bitwise(op, a, b);
          end
          it.acc = m_acc;
          it.age = 1;
          q.push_back(it);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    in_valid = v;
    op       = o;
    a        = x;
    b        = z;
  endtask

  logic [7:0] tt_exp [6] = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03};
  logic [7:0] ch_exp [4] = '{8'h00, 8'h12, 8'h26, 8'h60};
  logic       par_exp[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic       bub_exp[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] y0, acc0;
  logic [15:0] cnt0;

  initial begin
    // Reset state
    step();
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_y", y, 8'h00);
    chk("rst_acc", acc, 8'h00);
    chk("rst_count", count, 16'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Truth table with latency check
    out_ready = 1'b1;
    log_y.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'(i), 8'hF0, 8'hCC);
      step();
      if (i == 0) chk("lat_first_edge", out_valid, 1'b0);
      if (i == 1) begin
        chk("lat_second_edge", out_valid, 1'b1);
        chk("lat_y", y, 8'hC0);
      end
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) step();
    chk("tt_len", log_y.size(), 6);
    for (int i = 0; i < 6 && i < log_y.size(); i++) chk($sformatf("tt_y%0d", i), log_y[i], tt_exp[i]);

    // Checksum chain
    log_y.delete();
    log_par.delete();
    drive(1'b1, 3'd7, 8'h00, 8'h00); step();
    drive(1'b1, 3'd6, 8'h12, 8'h00); step();
    drive(1'b1, 3'd6, 8'h34, 8'h00); step();
    drive(1'b1, 3'd6, 8'h00, 8'h46); step();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) step();
    chk("chain_len", log_y.size(), 4);
    for (int i = 0; i < 4 && i < log_y.size(); i++) begin
      chk($sformatf("chain_y%0d", i), log_y[i], ch_exp[i]);
      chk($sformatf("chain_par%0d", i), log_par[i], par_exp[i]);
    end
    chk("chain_acc", acc, 8'h60);

    // Backpressure with a full pipe
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
      step();
    end
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready", in_ready, 1'b0);
    y0 = y; acc0 = acc; cnt0 = count;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      step();
      chk("bp_in_ready_hold", in_ready, 1'b0);
      chk("bp_y_hold", y, y0);
      chk("bp_acc_hold", acc, acc0);
      chk("bp_count_hold", count, cnt0);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("bp_drained", q.size(), 0);
    chk("bp_out_valid_low", out_valid, 1'b0);

    // Bubble propagation
    drive(1'b1, 3'd2, 8'hA5, 8'h0F); step();
    drive(1'b0, 3'd0, 8'h00, 8'h00); step();
    chk("bub_e2", out_valid, bub_exp[0]);
    drive(1'b1, 3'd1, 8'h50, 8'h05); step();
    chk("bub_e3", out_valid, bub_exp[1]);
    drive(1'b0, 3'd0, 8'h00, 8'h00); step();
    chk("bub_e4", out_valid, bub_exp[2]);
    step();
    chk("bub_e5", out_valid, bub_exp[3]);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("sat_count4", count4, 4'hF);

    // Mid-run reset with two ops in flight
    drive(1'b1, 3'd6, 8'h11, 8'h22); step();
    drive(1'b1, 3'd6, 8'h44, 8'h00); step();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_acc", acc, 8'h00);
    chk("mrst_count", count, 16'd0);
    step();
    rst_n = 1'b1;
    drive(1'b1, 3'd0, 8'hF0, 8'hCC);
    step();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    chk("mrst_lat1", out_valid, 1'b0);
    step();
    chk("mrst_lat2", out_valid, 1'b1);
    chk("mrst_y", y, 8'hC0);
    chk("mrst_acc_after", acc, 8'h00);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
